// File: rtl/parking_pkg.sv
// Shared state encoding and active-low 7-segment glyphs (gfedcba) for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PW = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_L     = 7'h47;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex-digit to active-low 7-segment decoder.
module seg7_hex (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  import parking_pkg::*;

  // Digit glyph lookup
  always_comb begin
    case (hex_i)
      4'h0:    seg_o = SEG_HEX_0;
      4'h1:    seg_o = SEG_HEX_1;
      4'h2:    seg_o = SEG_HEX_2;
      4'h3:    seg_o = SEG_HEX_3;
      4'h4:    seg_o = SEG_HEX_4;
      4'h5:    seg_o = SEG_HEX_5;
      4'h6:    seg_o = SEG_HEX_6;
      4'h7:    seg_o = SEG_HEX_7;
      4'h8:    seg_o = SEG_HEX_8;
      4'h9:    seg_o = SEG_HEX_9;
      4'hA:    seg_o = SEG_HEX_A;
      4'hB:    seg_o = SEG_HEX_B;
      4'hC:    seg_o = SEG_HEX_C;
      4'hD:    seg_o = SEG_HEX_D;
      4'hE:    seg_o = SEG_HEX_E;
      4'hF:    seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/parking_ctrl_gen.sv
// Parking gate controller: password-gated entry with retry lockout and timeout,
// exit counting, LEDs, gate strobe and two 7-segment digits (all outputs registered).
module parking_ctrl_gen
  import parking_pkg::*;
#(
  parameter int              CAPACITY    = 8,
  parameter int              PW_W        = 2,
  parameter logic [PW_W-1:0] PASS_1      = 2'b01,
  parameter logic [PW_W-1:0] PASS_2      = 2'b10,
  parameter int              MAX_TRIES   = 3,
  parameter int              WAIT_CYCLES = 1000,
  parameter int              LOCK_CYCLES = 256,
  localparam int             CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic [PW_W-1:0]  password_1,
  input  logic [PW_W-1:0]  password_2,
  input  logic             pw_valid,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic             gate_open,
  output logic             full,
  output logic [CNT_W-1:0] occupancy,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_2
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [TRY_W-1:0]  tries_q, tries_d, tries_inc_s;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              exit_prev_q, exit_prev_d;
  logic              green_q, green_d, red_q, red_d, gate_q, gate_d;
  logic [6:0]        hex1_q, hex1_d, hex2_q, hex2_s;
  logic [3:0]        occ_hex_s;
  logic              full_s, pw_ok_s, inc_s, dec_s;

  assign full_s      = (occ_q == CAP);
  assign pw_ok_s     = (password_1 == PASS_1) && (password_2 == PASS_2);
  assign tries_inc_s = tries_q + TRY_W'(1);
  assign inc_s       = (state_q == OPEN) && !sensor_entrance;
  assign dec_s       = sensor_exit && !exit_prev_q && (occ_q != CNT_W'(0));
  assign occ_hex_s   = 4'(occ_d);

  seg7_hex u_hex2 (
    .hex_i (occ_hex_s),
    .seg_o (hex2_s)
  );

  // State, timers, tries and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      lock_q      <= '0;
      tries_q     <= '0;
      occ_q       <= '0;
      exit_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      lock_q      <= lock_d;
      tries_q     <= tries_d;
      occ_q       <= occ_d;
      exit_prev_q <= exit_prev_d;
    end
  end

  // Next-state, timer and occupancy logic
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    lock_d      = lock_q;
    tries_d     = tries_q;
    exit_prev_d = sensor_exit;
    case (state_q)
      IDLE: begin
        if (sensor_entrance && !full_s) begin
          state_d = WAIT_PW;
          wait_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_PW: begin
        wait_d = wait_q + WAIT_W'(1);
        // A submission outranks both the car leaving and the timeout
        if (pw_valid) begin
          if (pw_ok_s) begin
            state_d = OPEN;
            tries_d = '0;
          end else if (tries_inc_s == TRY_MAX) begin
            state_d = LOCKOUT;
            tries_d = tries_inc_s;
            lock_d  = '0;
          end else begin
            tries_d = tries_inc_s;
            wait_d  = '0;
          end
        end else if (!sensor_entrance || (wait_q == WAIT_LAST)) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          state_d = WAIT_PW;
        end
      end
      OPEN: begin
        if (!sensor_entrance) begin
          state_d = IDLE;
        end else begin
          state_d = OPEN;
        end
      end
      LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          lock_d = lock_q + LOCK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (inc_s && dec_s) begin
      occ_d = occ_q;
    end else if (inc_s) begin
      occ_d = full_s ? occ_q : occ_q + CNT_W'(1);
    end else if (dec_s) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    green_d = 1'b0;
    gate_d  = 1'b0;
    red_d   = 1'b0;
    hex1_d  = SEG_BLANK;
    case (state_d)
      IDLE:    red_d = sensor_entrance && full_s;
      WAIT_PW: begin red_d = 1'b1; hex1_d = SEG_E; end
      OPEN:    begin green_d = 1'b1; gate_d = 1'b1; hex1_d = SEG_G; end
      LOCKOUT: begin red_d = 1'b1; hex1_d = SEG_L; end
      default: hex1_d = SEG_BLANK;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      green_q <= 1'b0;
      red_q   <= 1'b0;
      gate_q  <= 1'b0;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_HEX_0;
    end else begin
      green_q <= green_d;
      red_q   <= red_d;
      gate_q  <= gate_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_s;
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign gate_open = gate_q;
  assign full      = full_s;
  assign occupancy = occ_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;

endmodule

// File: tb/tb_parking_ctrl_gen.sv
// Directed scenarios plus randomized traffic against a countdown-style behavioural model.
module tb_parking_ctrl_gen;

  localparam int CAP         = 8;
  localparam int WAIT_CYCLES = 1000;
  localparam int LOCK_CYCLES = 256;
  localparam int MAX_TRIES   = 3;
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_G     = 7'h42;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] DIGITS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam int M_IDLE = 0, M_WAIT = 1, M_OPEN = 2, M_LOCK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic [1:0] password_1 = 2'd0;
  logic [1:0] password_2 = 2'd0;
  logic       pw_valid = 1'b0;
  logic       GREEN_LED, RED_LED, gate_open, full;
  logic [3:0] occupancy;
  logic [6:0] HEX_1, HEX_2;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int         m_state = M_IDLE, m_occ = 0, m_tries = 0, m_wait_left = 0, m_lock_left = 0;
  bit         m_exit_prev = 1'b0;
  logic       m_green = 1'b0, m_red = 1'b0, m_gate = 1'b0;
  logic [6:0] m_hex1 = G_BLANK;

  parking_ctrl_gen dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .pw_valid        (pw_valid),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .gate_open       (gate_open),
    .full            (full),
    .occupancy       (occupancy),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int ns;
    bit inc, dec, full_now;
    if (reset) begin
      m_state = M_IDLE; m_occ = 0; m_tries = 0; m_wait_left = 0; m_lock_left = 0;
      m_exit_prev = 1'b0; m_green = 1'b0; m_red = 1'b0; m_gate = 1'b0; m_hex1 = G_BLANK;
      return;
    end
    full_now = (m_occ == CAP);
    inc = (m_state == M_OPEN) && !sensor_entrance;
    dec = sensor_exit && !m_exit_prev && (m_occ > 0);
    m_exit_prev = sensor_exit;
    ns = m_state;
    case (m_state)
      M_IDLE: if (sensor_entrance && !full_now) begin ns = M_WAIT; m_wait_left = WAIT_CYCLES; end
      M_WAIT: begin
        if (pw_valid) begin
          if (password_1 == 2'd1 && password_2 == 2'd2) begin ns = M_OPEN; m_tries = 0; end
          else begin
            m_tries++;
            if (m_tries >= MAX_TRIES) begin ns = M_LOCK; m_lock_left = LOCK_CYCLES; end
            else m_wait_left = WAIT_CYCLES;
          end
        end else if (!sensor_entrance) begin
          ns = M_IDLE; m_tries = 0;
        end else begin
          m_wait_left--;
          if (m_wait_left == 0) begin ns = M_IDLE; m_tries = 0; end
        end
      end
      M_OPEN: if (!sensor_entrance) ns = M_IDLE;
      default: begin
        m_lock_left--;
        if (m_lock_left == 0) begin ns = M_IDLE; m_tries = 0; end
      end
    endcase
    if (inc && dec) m_occ = m_occ;
    else if (inc) m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
    else if (dec) m_occ = m_occ - 1;
    m_state = ns;
    m_green = (ns == M_OPEN);
    m_gate  = (ns == M_OPEN);
    m_red   = (ns == M_WAIT) || (ns == M_LOCK) || (ns == M_IDLE && sensor_entrance && full_now);
    m_hex1  = (ns == M_WAIT) ? G_E : (ns == M_OPEN) ? G_G : (ns == M_LOCK) ? G_L : G_BLANK;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic park_one();
    sensor_entrance = 1'b1; tick();
    pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd2; tick();
    pw_valid = 1'b0; sensor_entrance = 1'b0; tick();
  endtask

  task automatic exit_pulse();
    sensor_exit = 1'b1; tick();
    sensor_exit = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    vectors++; if ({GREEN_LED, RED_LED, gate_open, full} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {GREEN_LED, RED_LED, gate_open, full}); end
    vectors++; if (HEX_1 !== 7'h7F) begin miscompares++; $display("FAIL reset_hex1: got %h want 7f", HEX_1); end
    vectors++; if (HEX_2 !== 7'h40) begin miscompares++; $display("FAIL reset_hex2: got %h want 40", HEX_2); end
  endtask

  task automatic test_entry();
    sensor_entrance = 1'b1; tick();
    vectors++; if (RED_LED !== 1'b1 || HEX_1 !== G_E) begin miscompares++; $display("FAIL entry_wait: got red=%b hex1=%h want red=1 hex1=%h", RED_LED, HEX_1, G_E); end
    pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd2; tick();
    pw_valid = 1'b0;
    vectors++; if (GREEN_LED !== 1'b1 || gate_open !== 1'b1 || HEX_1 !== G_G) begin miscompares++; $display("FAIL entry_open: got green=%b gate=%b hex1=%h want 1 1 %h", GREEN_LED, gate_open, HEX_1, G_G); end
    sensor_entrance = 1'b0; tick();
    vectors++; if (occupancy !== 4'd1 || HEX_2 !== 7'h79) begin miscompares++; $display("FAIL entry_count: got occ=%0d hex2=%h want 1 79", occupancy, HEX_2); end
    vectors++; if (GREEN_LED !== 1'b0 || gate_open !== 1'b0 || HEX_1 !== G_BLANK) begin miscompares++; $display("FAIL entry_idle: got green=%b gate=%b hex1=%h want 0 0 7f", GREEN_LED, gate_open, HEX_1); end
  endtask

  task automatic test_lockout();
    int lock_cycles, green_seen, red_gap;
    sensor_entrance = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd1; tick();
      pw_valid = 1'b0;
      if (k < 2) begin
        vectors++; if (HEX_1 !== G_E) begin miscompares++; $display("FAIL lock_retry%0d: got hex1=%h want %h", k, HEX_1, G_E); end
        tick();
      end
    end
    vectors++; if (HEX_1 !== G_L || RED_LED !== 1'b1) begin miscompares++; $display("FAIL lock_enter: got hex1=%h red=%b want %h 1", HEX_1, RED_LED, G_L); end
    lock_cycles = 1; green_seen = 0; red_gap = 0;
    for (int i = 1; i < 400; i++) begin
      if (i == 10) begin pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd2; end
      else pw_valid = 1'b0;
      if (i == 20) sensor_entrance = 1'b0;
      tick();
      if (GREEN_LED) green_seen++;
      if (HEX_1 !== G_L) break;
      if (!RED_LED) red_gap++;
      lock_cycles++;
    end
    vectors++; if (lock_cycles != LOCK_CYCLES) begin miscompares++; $display("FAIL lock_len: got %0d want %0d", lock_cycles, LOCK_CYCLES); end
    vectors++; if (green_seen != 0 || red_gap != 0) begin miscompares++; $display("FAIL lock_ignore: got green=%0d redgap=%0d want 0 0", green_seen, red_gap); end
    vectors++; if (HEX_1 !== G_BLANK || RED_LED !== 1'b0) begin miscompares++; $display("FAIL lock_exit: got hex1=%h red=%b want 7f 0", HEX_1, RED_LED); end
  endtask

  task automatic test_full();
    while (m_occ < CAP) park_one();
    vectors++; if (full !== 1'b1 || occupancy !== 4'd8 || HEX_2 !== 7'h00) begin miscompares++; $display("FAIL full_set: got full=%b occ=%0d hex2=%h want 1 8 00", full, occupancy, HEX_2); end
    sensor_entrance = 1'b1; tick(); tick();
    vectors++; if (RED_LED !== 1'b1 || HEX_1 !== G_BLANK || GREEN_LED !== 1'b0) begin miscompares++; $display("FAIL full_refuse: got red=%b hex1=%h green=%b want 1 7f 0", RED_LED, HEX_1, GREEN_LED); end
    sensor_entrance = 1'b0; tick();
    vectors++; if (RED_LED !== 1'b0) begin miscompares++; $display("FAIL full_red_clear: got %b want 0", RED_LED); end
    exit_pulse();
    vectors++; if (occupancy !== 4'd7 || full !== 1'b0) begin miscompares++; $display("FAIL full_exit: got occ=%0d full=%b want 7 0", occupancy, full); end
  endtask

  task automatic test_timeout();
    int e_count;
    while (m_occ > 0) exit_pulse();
    exit_pulse();
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL exit_underflow: got %0d want 0", occupancy); end
    sensor_entrance = 1'b1; tick();
    password_1 = 2'd1; password_2 = 2'd1;
    pw_valid = 1'b1; tick(); pw_valid = 1'b0; tick();
    pw_valid = 1'b1; tick(); pw_valid = 1'b0;
    e_count = 1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (HEX_1 !== G_E) break;
      e_count++;
    end
    vectors++; if (e_count != WAIT_CYCLES) begin miscompares++; $display("FAIL timeout_len: got %0d want %0d", e_count, WAIT_CYCLES); end
    vectors++; if (HEX_1 !== G_BLANK || RED_LED !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: got hex1=%h red=%b want 7f 0", HEX_1, RED_LED); end
    tick();
    pw_valid = 1'b1; tick(); pw_valid = 1'b0;
    vectors++; if (HEX_1 !== G_E) begin miscompares++; $display("FAIL timeout_tries_cleared: got hex1=%h want %h", HEX_1, G_E); end
    sensor_entrance = 1'b0; tick();
    vectors++; if (HEX_1 !== G_BLANK) begin miscompares++; $display("FAIL wait_abandon: got hex1=%h want 7f", HEX_1); end
  endtask

  task automatic test_simultaneous();
    repeat (3) park_one();
    vectors++; if (occupancy !== 4'd3) begin miscompares++; $display("FAIL simul_pre: got %0d want 3", occupancy); end
    sensor_entrance = 1'b1; tick();
    pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd2; tick();
    pw_valid = 1'b0; sensor_entrance = 1'b0; sensor_exit = 1'b1; tick();
    sensor_exit = 1'b0;
    vectors++; if (occupancy !== 4'd3 || HEX_1 !== G_BLANK) begin miscompares++; $display("FAIL simul_occ: got occ=%0d hex1=%h want 3 7f", occupancy, HEX_1); end
    tick();
  endtask

  task automatic test_reset_open();
    sensor_entrance = 1'b1; tick();
    pw_valid = 1'b1; password_1 = 2'd1; password_2 = 2'd2; tick();
    pw_valid = 1'b0;
    vectors++; if (gate_open !== 1'b1) begin miscompares++; $display("FAIL rst_open_pre: got %b want 1", gate_open); end
    reset = 1'b1; tick();
    vectors++; if (gate_open !== 1'b0 || GREEN_LED !== 1'b0 || occupancy !== 4'd0 || HEX_2 !== 7'h40) begin miscompares++; $display("FAIL rst_open: got gate=%b green=%b occ=%0d hex2=%h want 0 0 0 40", gate_open, GREEN_LED, occupancy, HEX_2); end
    reset = 1'b0; sensor_entrance = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [21:0] got, want;
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) sensor_entrance = ~sensor_entrance;
      if ($urandom_range(0, 11) == 0) sensor_exit = ~sensor_exit;
      pw_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) begin password_1 = 2'd1; password_2 = 2'd2; end
      else begin password_1 = 2'($urandom_range(0, 3)); password_2 = 2'($urandom_range(0, 3)); end
      tick();
      got  = {GREEN_LED, RED_LED, gate_open, full, occupancy, HEX_1, HEX_2};
      want = {m_green, m_red, m_gate, (m_occ == CAP), 4'(m_occ), m_hex1, DIGITS[m_occ]};
      vectors++;
      if (got !== want) begin
        miscompares++; errs++;
        if (errs <= 10) $display("FAIL random cycle %0d: got %h want %h", i, got, want);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_lockout();
    test_full();
    test_timeout();
    test_simultaneous();
    test_reset_open();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
